ether_gmii_tx: RTL
==================

ETHER_GMII_TX -- requirements
Module: ether_gmii_tx

Interface
REQ-001 Parameter IFG_CYCLES, default 12, idle cycles (tx_en=0) between frames.
REQ-002 Parameter MIN_FRAME, default 60, minimum payload+pad byte count before FCS; 0 disables padding.
REQ-003 clk_125  input  1  125 MHz transmit clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 phy_rst  input  1  PHY reset release: 1 = PHY out of reset, transmit enabled; 0 = hold/abort.
REQ-006 tx_data  input  8  payload byte (destination MAC first).
REQ-007 tx_valid  input  1  tx_data valid; also requests frame start when idle.
REQ-008 tx_last  input  1  marks final payload byte; sampled with tx_valid.
REQ-009 tx_ready  output  1  byte accepted when tx_valid & tx_ready.
REQ-010 gmii_txd  output  8  GMII transmit data, registered.
REQ-011 gmii_tx_en  output  1  GMII transmit enable, registered.
REQ-012 gmii_tx_er  output  1  GMII transmit error, registered.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 frame_cnt  output  16  frames completed with FCS, wraps 0xFFFF->0x0000.
REQ-015 err_cnt  output  16  frames aborted (underrun or phy_rst drop), wraps.

Function
REQ-016 States: IDLE, PRE, SFD, DATA, PAD, FCS, IFG; state names what gmii outputs carry that cycle.
REQ-017 IDLE: tx_en=0, txd=0x00, tx_ready=0; tx_valid=1 and phy_rst=1 -> PRE next cycle (start byte not consumed).
REQ-018 PRE: 7 cycles txd=0x55, tx_en=1 -> SFD.
REQ-019 SFD: 1 cycle txd=0xD5, tx_en=1, tx_ready=1 -> DATA.
REQ-020 tx_ready=1 in SFD and in DATA until the tx_last byte is accepted; 0 everywhere else.
REQ-021 Byte accepted in cycle n appears on gmii_txd in cycle n+1; no bubbles within a frame.
REQ-022 DATA: after tx_last byte output, -> PAD if byte count < MIN_FRAME, else FCS.
REQ-023 PAD: txd=0x00 until payload+pad count = MIN_FRAME, -> FCS; byte counter 16 bits, saturating.
REQ-024 CRC-32 (poly 0x04C11DB7 reflected, init 0xFFFFFFFF, final complement) over payload+pad, excluding preamble/SFD.
REQ-025 FCS: 4 cycles, FCS least-significant byte first, tx_en=1 -> IFG; frame_cnt+1 on last FCS byte.
REQ-026 IFG: IFG_CYCLES cycles tx_en=0, txd=0x00 -> IDLE; new start evaluated only in IDLE.
REQ-027 Underrun: tx_ready=1 and tx_valid=0 -> next cycle tx_en=1, tx_er=1, txd=0x00 for 1 cycle, then IFG; no FCS; err_cnt+1.
REQ-028 phy_rst=0 in any state other than IDLE/IFG -> next cycle tx_en=0, tx_er=0, tx_ready=0, state IFG; err_cnt+1; upstream discards rest of frame.
REQ-029 phy_rst=0 in IDLE: no frame starts; tx_ready stays 0.
REQ-030 tx_last and underrun cannot coincide; tx_last sampled only on accepted bytes.
REQ-031 tx_er=0 in all cycles except REQ-027.

Reset
REQ-032 rst=1 -> state IDLE, gmii_txd=0x00, gmii_tx_en=0, gmii_tx_er=0, tx_ready=0, busy=0, frame_cnt=0, err_cnt=0, CRC=0xFFFFFFFF, asynchronously.
REQ-033 rst mid-frame: outputs drop immediately, no counter update; first frame after release starts with full preamble.

Verification
REQ-034 Single byte 0xAA, tx_last=1 -> 7x0x55, 0xD5, 0xAA, 59x0x00, 4 FCS; tx_en high 72 cycles, then 12 cycles low; frame_cnt=1.
REQ-035 MIN_FRAME=0, payload ASCII "123456789" -> FCS bytes 0x26,0x39,0xF4,0xCB after 0x39.
REQ-036 64-byte random payload -> no pad; CRC (init 0xFFFFFFFF, no final xor) over emitted payload+FCS = 0xDEBB20E3.
REQ-037 tx_valid dropped after 10 accepted bytes -> one cycle tx_en=1, tx_er=1, then 12 idle cycles; err_cnt=1, frame_cnt=0.
REQ-038 phy_rst forced 0 during PAD -> tx_en=0 next cycle, err_cnt=1; phy_rst=0 in IDLE with tx_valid=1 -> tx_en stays 0.
REQ-039 Back-to-back frames, tx_valid held high -> exactly IFG_CYCLES idle cycles plus 1 IDLE cycle between last FCS byte and next 0x55.

Source files
------------

// File: rtl/ether_gmii_tx.sv
// Gigabit Ethernet GMII transmitter.
// Frames an upstream byte stream with preamble and SFD, pads short frames,
// appends the CRC-32 FCS and enforces the inter-frame gap. Underruns are
// signalled on the wire with tx_er; a PHY reset drop silently truncates.
module ether_gmii_tx #(
   parameter int IFG_CYCLES = 12,
   parameter int MIN_FRAME  = 60
) (
   input  logic        clk_125,
   input  logic        rst,
   input  logic        phy_rst,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   input  logic        tx_last,
   output logic        tx_ready,
   output logic [7:0]  gmii_txd,
   output logic        gmii_tx_en,
   output logic        gmii_tx_er,
   output logic        busy,
   output logic [15:0] frame_cnt,
   output logic [15:0] err_cnt
);

   // Each state names what the GMII outputs carry during that cycle.
   // S_ERR is the single tx_er cycle that marks an underrun on the wire.
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PRE  = 3'd1;
   localparam logic [2:0] S_SFD  = 3'd2;
   localparam logic [2:0] S_DATA = 3'd3;
   localparam logic [2:0] S_PAD  = 3'd4;
   localparam logic [2:0] S_FCS  = 3'd5;
   localparam logic [2:0] S_IFG  = 3'd6;
   localparam logic [2:0] S_ERR  = 3'd7;

   localparam logic [16:0] MIN_LEN  = 17'(MIN_FRAME);
   localparam logic [15:0] IFG_LAST = 16'((IFG_CYCLES > 0) ? (IFG_CYCLES - 1) : 0);

   logic [2:0]  state_q, state_d;
   logic [15:0] phase_q, phase_d;       // preamble / FCS / IFG position
   logic [15:0] byte_cnt_q, byte_cnt_d; // payload+pad bytes, saturating
   logic [31:0] crc_q, crc_d;
   logic        last_done_q, last_done_d;
   logic [7:0]  txd_q, txd_d;
   logic        en_q, en_d;
   logic        er_q, er_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [15:0] err_cnt_q, err_cnt_d;

   logic [7:0]  crc_in;
   logic [31:0] crc_chain [0:8];
   logic [31:0] crc_upd;
   logic [31:0] fcs_val;
   logic [15:0] byte_cnt_inc;
   logic        pad_needed;
   logic        abort;

   assign tx_ready = (state_q == S_SFD) || ((state_q == S_DATA) && !last_done_q);

   // A PHY reset drop kills any frame that is on the wire; IFG/IDLE are safe.
   assign abort = !phy_rst && ((state_q == S_PRE) || (state_q == S_SFD) ||
                               (state_q == S_DATA) || (state_q == S_PAD) ||
                               (state_q == S_FCS));

   // While accepting bytes the CRC eats upstream data, otherwise pad zeros.
   assign crc_in = tx_ready ? tx_data : 8'h00;

   // Reflected CRC-32, one bit per chain stage, LSB of the byte first.
   assign crc_chain[0] = crc_q ^ {24'h000000, crc_in};
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_crc_bit
         assign crc_chain[gi+1] = crc_chain[gi][0]
                                  ? ({1'b0, crc_chain[gi][31:1]} ^ 32'hEDB88320)
                                  : {1'b0, crc_chain[gi][31:1]};
      end
   endgenerate
   assign crc_upd = crc_chain[8];
   assign fcs_val = ~crc_q;

   assign byte_cnt_inc = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : (byte_cnt_q + 16'd1);
   // Written as cnt+1 <= MIN so a zero MIN_FRAME needs no special case.
   assign pad_needed   = ({1'b0, byte_cnt_q} + 17'd1) <= MIN_LEN;

   // Next-state and next-output computation for the transmit sequencer.
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      byte_cnt_d  = byte_cnt_q;
      crc_d       = crc_q;
      last_done_d = last_done_q;
      txd_d       = 8'h00;
      en_d        = 1'b0;
      er_d        = 1'b0;
      frame_cnt_d = frame_cnt_q;
      err_cnt_d   = err_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (tx_valid && phy_rst) begin
               state_d     = S_PRE;
               phase_d     = 16'd0;
               byte_cnt_d  = 16'd0;
               crc_d       = 32'hFFFFFFFF;
               last_done_d = 1'b0;
               txd_d       = 8'h55;
               en_d        = 1'b1;
            end
         end
         S_PRE: begin
            en_d = 1'b1;
            if (phase_q == 16'd6) begin
               state_d = S_SFD;
               txd_d   = 8'hD5;
            end else begin
               phase_d = phase_q + 16'd1;
               txd_d   = 8'h55;
            end
         end
         S_SFD, S_DATA, S_PAD: begin
            en_d = 1'b1;
            if (tx_ready) begin
               if (tx_valid) begin
                  state_d     = S_DATA;
                  txd_d       = tx_data;
                  crc_d       = crc_upd;
                  byte_cnt_d  = byte_cnt_inc;
                  last_done_d = tx_last;
               end else begin
                  // Upstream starved us mid-frame: poison it on the wire.
                  state_d   = S_ERR;
                  er_d      = 1'b1;
                  err_cnt_d = err_cnt_q + 16'd1;
               end
            end else if (pad_needed) begin
               state_d    = S_PAD;
               crc_d      = crc_upd;
               byte_cnt_d = byte_cnt_inc;
            end else begin
               state_d = S_FCS;
               phase_d = 16'd0;
               txd_d   = fcs_val[7:0];
            end
         end
         S_FCS: begin
            en_d = 1'b1;
            if (phase_q[1:0] == 2'd3) begin
               state_d     = S_IFG;
               phase_d     = 16'd0;
               en_d        = 1'b0;
               frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
               phase_d = phase_q + 16'd1;
               case (phase_q[1:0])
                  2'd0:    txd_d = fcs_val[15:8];
                  2'd1:    txd_d = fcs_val[23:16];
                  default: txd_d = fcs_val[31:24];
               endcase
            end
         end
         S_ERR: begin
            state_d = S_IFG;
            phase_d = 16'd0;
         end
         S_IFG: begin
            if (phase_q >= IFG_LAST) begin
               state_d = S_IDLE;
            end else begin
               phase_d = phase_q + 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // PHY reset drop overrides everything, including a coincident underrun.
      if (abort) begin
         state_d     = S_IFG;
         phase_d     = 16'd0;
         txd_d       = 8'h00;
         en_d        = 1'b0;
         er_d        = 1'b0;
         frame_cnt_d = frame_cnt_q;
         err_cnt_d   = err_cnt_q + 16'd1;
      end
   end

   // State and registered GMII outputs; reset drops the wire immediately.
   always_ff @(posedge clk_125 or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         phase_q     <= 16'd0;
         byte_cnt_q  <= 16'd0;
         crc_q       <= 32'hFFFFFFFF;
         last_done_q <= 1'b0;
         txd_q       <= 8'h00;
         en_q        <= 1'b0;
         er_q        <= 1'b0;
         frame_cnt_q <= 16'd0;
         err_cnt_q   <= 16'd0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         byte_cnt_q  <= byte_cnt_d;
         crc_q       <= crc_d;
         last_done_q <= last_done_d;
         txd_q       <= txd_d;
         en_q        <= en_d;
         er_q        <= er_d;
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign gmii_txd   = txd_q;
   assign gmii_tx_en = en_q;
   assign gmii_tx_er = er_q;
   assign busy       = (state_q != S_IDLE);
   assign frame_cnt  = frame_cnt_q;
   assign err_cnt    = err_cnt_q;

endmodule
